// File: rtl/p2_pkg.sv
// Shared protocol-2 packet constants, FSM state type and header byte helper
// used by the DDC, mic and wideband packet builders.
package p2_pkg;

  localparam int unsigned HDR_BYTES             = 16;
  localparam int unsigned DDC_SAMPLES_PER_FRAME = 238;
  localparam int unsigned DDC_PKT_BYTES         = HDR_BYTES + 6 * DDC_SAMPLES_PER_FRAME;

  // Header field start offsets (bytes); every field is big-endian.
  localparam logic [3:0] HDR_OFS_SEQ = 4'd0;
  localparam logic [3:0] HDR_OFS_TS  = 4'd4;
  localparam logic [3:0] HDR_OFS_BPS = 4'd12;
  localparam logic [3:0] HDR_OFS_SPF = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HDR  = 2'd2,
    PAY  = 2'd3
  } p2_state_e;

  // Byte 'rel' (0 = most significant) of an nbytes-wide field held right-aligned.
  function automatic logic [7:0] be_byte(input logic [63:0] field,
                                         input logic [3:0]  nbytes,
                                         input logic [3:0]  rel);
    logic [2:0] pos;
    pos = 3'(nbytes - 4'd1 - rel);
    return field[{pos, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/p2_hdr_mux.sv
// Combinational byte select of the 16-byte protocol-2 header
// {seq, timestamp, bits-per-sample, samples-per-frame} by byte index.
module p2_hdr_mux
  import p2_pkg::*;
(
  input  logic [3:0]  idx_i,
  input  logic [31:0] seq_i,
  input  logic [63:0] ts_i,
  input  logic [15:0] bps_i,
  input  logic [15:0] spf_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = '0;
    if (idx_i >= HDR_OFS_SPF) begin
      byte_o = be_byte({48'd0, spf_i}, 4'd2, idx_i - HDR_OFS_SPF);
    end else if (idx_i >= HDR_OFS_BPS) begin
      byte_o = be_byte({48'd0, bps_i}, 4'd2, idx_i - HDR_OFS_BPS);
    end else if (idx_i >= HDR_OFS_TS) begin
      byte_o = be_byte(ts_i, 4'd8, idx_i - HDR_OFS_TS);
    end else begin
      byte_o = be_byte({32'd0, seq_i}, 4'd4, idx_i - HDR_OFS_SEQ);
    end
  end

endmodule

// File: rtl/ddc_packet_builder.sv
// Drains one buffered frame of DDC I/Q bytes from the byte FIFO and emits it
// as a protocol-2 UDP payload (16-byte header + 6*SAMPLES_PER_FRAME bytes).
module ddc_packet_builder
  import p2_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_FRAME = (DDC_PKT_BYTES - HDR_BYTES) / 6,
  parameter int unsigned BITS_PER_SAMPLE   = 24,
  parameter int unsigned USEDW_W           = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               fifo_clear,
  input  logic [USEDW_W-1:0] fifo_rdusedw,
  input  logic [7:0]         fifo_rddata,
  output logic               fifo_rdreq,
  input  logic [63:0]        timestamp,
  output logic               tx_request,
  input  logic               tx_grant,
  output logic [10:0]        tx_length,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_last,
  output logic               pkt_aborted
);

  localparam int unsigned PAY_BYTES = 6 * SAMPLES_PER_FRAME;
  localparam int unsigned PKT_BYTES = HDR_BYTES + PAY_BYTES;
  localparam logic [10:0] HDR_LAST  = 11'(HDR_BYTES - 1);
  localparam logic [10:0] PAY_LAST  = 11'(PAY_BYTES - 1);

  p2_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] seq_q, seq_d;
  logic [63:0] ts_q, ts_d;
  logic        aborted_q, aborted_d;
  logic        kill;
  logic        threshold_met;
  logic [7:0]  hdr_byte;

  assign tx_length     = 11'(PKT_BYTES);
  assign threshold_met = 32'(fifo_rdusedw) >= 32'(PAY_BYTES);

  p2_hdr_mux u_hdr_mux (
    .idx_i  (cnt_q[3:0]),
    .seq_i  (seq_q),
    .ts_i   (ts_q),
    .bps_i  (16'(BITS_PER_SAMPLE)),
    .spf_i  (16'(SAMPLES_PER_FRAME)),
    .byte_o (hdr_byte)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    ts_d        = ts_q;
    aborted_d   = aborted_q;
    tx_request  = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    tx_last     = 1'b0;
    fifo_rdreq  = 1'b0;
    pkt_aborted = 1'b0;
    // Once a flush is seen the packet is padded with zeros to keep MAC framing.
    kill        = aborted_q | fifo_clear;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        aborted_d = 1'b0;
        if (!run) begin
          seq_d = '0;
        end else if (!fifo_clear && threshold_met) begin
          ts_d    = timestamp;
          state_d = REQ;
        end
      end
      REQ: begin
        tx_request = 1'b1;
        if (fifo_clear) begin
          state_d = IDLE;
        end else if (tx_grant) begin
          cnt_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        tx_valid    = 1'b1;
        tx_data     = kill ? 8'h00 : hdr_byte;
        pkt_aborted = fifo_clear & ~aborted_q;
        aborted_d   = kill;
        // Prefetch on the last header byte so payload byte 0 is on q in time.
        fifo_rdreq  = (cnt_q == HDR_LAST) & ~kill;
        if (cnt_q == HDR_LAST) begin
          cnt_d   = '0;
          state_d = PAY;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      PAY: begin
        tx_valid    = 1'b1;
        tx_data     = kill ? 8'h00 : fifo_rddata;
        pkt_aborted = fifo_clear & ~aborted_q;
        aborted_d   = kill;
        fifo_rdreq  = (cnt_q != PAY_LAST) & ~kill;
        if (cnt_q == PAY_LAST) begin
          tx_last = 1'b1;
          seq_d   = seq_q + 32'd1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seq_q     <= '0;
      ts_q      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      ts_q      <= ts_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_ddc_packet_builder.sv
// Self-checking bench for ddc_packet_builder: byte-FIFO model, packet capture
// monitor and a frame-level reference built from the packet format rules.
module tb_ddc_packet_builder;

  localparam int unsigned SPF = 238;
  localparam int unsigned PAY = 6 * SPF;
  localparam int unsigned PKT = 16 + PAY;

  logic        clock = 1'b0;
  logic        reset, run, fifo_clear, tx_grant;
  logic [11:0] fifo_rdusedw;
  logic [7:0]  fifo_rddata = 8'h00;
  logic        fifo_rdreq, tx_request, tx_valid, tx_last, pkt_aborted;
  logic [7:0]  tx_data;
  logic [10:0] tx_length;
  logic [63:0] timestamp;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ddc_packet_builder #(
    .SAMPLES_PER_FRAME (SPF),
    .BITS_PER_SAMPLE   (24),
    .USEDW_W           (12)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .fifo_clear   (fifo_clear),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_rddata  (fifo_rddata),
    .fifo_rdreq   (fifo_rdreq),
    .timestamp    (timestamp),
    .tx_request   (tx_request),
    .tx_grant     (tx_grant),
    .tx_length    (tx_length),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .pkt_aborted  (pkt_aborted)
  );

  // Non-show-ahead byte FIFO model; fill level can be overridden for threshold tests.
  byte unsigned fq[$];
  logic [11:0]  level_q = '0;
  logic         ovr_en = 1'b0;
  logic [11:0]  ovr_val = '0;
  int           underflows = 0;
  assign fifo_rdusedw = ovr_en ? ovr_val : level_q;

  always @(posedge clock) begin
    if (fifo_clear) begin
      fq.delete();
    end else if (fifo_rdreq) begin
      if (fq.size() == 0) underflows++;
      else fifo_rddata <= fq.pop_front();
    end
    level_q <= 12'(fq.size());
  end

  // Packet capture monitor, sampled away from the active edge.
  byte unsigned cap[$];
  int cyc = 0, first_cyc = 0, last_cyc = 0;
  int last_cnt = 0, last_idx = -1, rd_cnt = 0, abort_cnt = 0;

  always @(negedge clock) begin
    cyc++;
    if (tx_valid) begin
      if (cap.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      cap.push_back(tx_data);
      if (tx_last) begin
        last_cnt++;
        last_idx = cap.size() - 1;
      end
    end else if (tx_last) begin
      last_cnt++;
    end
    if (fifo_rdreq)  rd_cnt++;
    if (pkt_aborted) abort_cnt++;
  end

  byte unsigned exp_pay [PAY];
  logic [31:0]  exp_seq = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input bit random_fill);
    for (int i = 0; i < PAY; i++) begin
      exp_pay[i] = random_fill ? 8'($urandom) : 8'(i);
      fq.push_back(exp_pay[i]);
    end
  endtask

  function automatic logic [63:0] cap_be(input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = (v << 8) | ((from + i < cap.size()) ? 64'(cap[from + i]) : 64'd0);
    end
    return v;
  endfunction

  // Waits for a request, grants after gdly cycles and follows the packet.
  // clr_at / drop_at / rst_at are packet byte indices (-1 = not used).
  task automatic run_pkt(input string tag, input int gdly, input int clr_at,
                         input int drop_at, input int rst_at, input logic [63:0] ts_exp);
    int n, nbad, first_bad, exp_rd;
    byte unsigned e, a;
    cap.delete();
    last_cnt = 0; last_idx = -1; rd_cnt = 0; abort_cnt = 0;
    n = 0;
    while (!tx_request && n < 300) begin step(); n++; end
    chk($sformatf("%s tx_request seen", tag), tx_request, 1);
    if (!tx_request) return;
    repeat (gdly) begin
      timestamp = {$urandom, $urandom};
      step();
    end
    tx_grant = 1'b1;
    n = 0;
    while (!tx_valid && n < 10) begin step(); n++; end
    chk($sformatf("%s tx_valid after grant", tag), tx_valid, 1);
    if (!tx_valid) begin tx_grant = 1'b0; return; end
    for (int k = 0; k < PKT + 4; k++) begin
      fifo_clear = (k == clr_at);
      timestamp  = {$urandom, $urandom};
      if (k == drop_at) run = 1'b0;
      if (k == rst_at) begin
        reset = 1'b1; tx_grant = 1'b0;
        step();
        return;
      end
      if (tx_last) begin step(); break; end
      step();
    end
    fifo_clear = 1'b0;
    tx_grant   = 1'b0;

    chk($sformatf("%s length", tag), cap.size(), PKT);
    chk($sformatf("%s contiguous", tag), last_cyc - first_cyc + 1, cap.size());
    chk($sformatf("%s seq", tag), cap_be(0, 4), {32'd0, exp_seq});
    chk($sformatf("%s timestamp", tag), cap_be(4, 8), ts_exp);
    chk($sformatf("%s bps/spf", tag), cap_be(12, 4), 64'h0018_00EE);
    nbad = 0; first_bad = -1;
    for (int i = 0; i < PAY; i++) begin
      e = (clr_at >= 0 && i + 16 >= clr_at) ? 8'h00 : exp_pay[i];
      a = (16 + i < cap.size()) ? cap[16 + i] : 8'h00;
      if (a != e) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk($sformatf("%s payload mismatches (first at %0d)", tag, first_bad), nbad, 0);
    chk($sformatf("%s tx_last count", tag), last_cnt, 1);
    chk($sformatf("%s tx_last index", tag), last_idx, PKT - 1);
    exp_rd = (clr_at < 0) ? PAY : ((clr_at < 16) ? 0 : clr_at - 16 + 1);
    chk($sformatf("%s rdreq count", tag), rd_cnt, exp_rd);
    chk($sformatf("%s pkt_aborted pulses", tag), abort_cnt, (clr_at >= 0) ? 1 : 0);
    chk($sformatf("%s underflows", tag), underflows, 0);
    exp_seq = exp_seq + 32'd1;
  endtask

  typedef struct {
    bit run;
    bit clr;
    int usedw;
    bit exp_req;
  } thr_vec_t;

  thr_vec_t tv [8];

  initial begin
    logic [63:0] t;
    int n_req;
    tv[0] = '{1'b1, 1'b0, 1427, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1428, 1'b1};
    tv[2] = '{1'b0, 1'b0, 1428, 1'b0};
    tv[3] = '{1'b1, 1'b1, 1500, 1'b0};
    tv[4] = '{1'b1, 1'b0, 4095, 1'b1};
    tv[5] = '{1'b1, 1'b0, 0,    1'b0};
    tv[6] = '{1'b0, 1'b1, 0,    1'b0};
    tv[7] = '{1'b1, 1'b0, 1429, 1'b1};

    reset = 1'b1; run = 1'b0; fifo_clear = 1'b0; tx_grant = 1'b0; timestamp = '0;
    repeat (3) step();
    chk("reset tx_request", tx_request, 0);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset tx_last", tx_last, 0);
    chk("reset fifo_rdreq", fifo_rdreq, 0);
    chk("reset pkt_aborted", pkt_aborted, 0);
    chk("tx_length", tx_length, PKT);
    reset = 1'b0;
    step();

    // Start-threshold vectors; any request raised is withdrawn via fifo_clear in REQ.
    ovr_en = 1'b1;
    abort_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      run = tv[i].run; fifo_clear = tv[i].clr; ovr_val = 12'(tv[i].usedw);
      step();
      chk($sformatf("thr[%0d] tx_request", i), tx_request, tv[i].exp_req);
      fifo_clear = 1'b1; ovr_val = '0;
      step();
      chk($sformatf("thr[%0d] request dropped by clear", i), tx_request, 0);
      fifo_clear = 1'b0;
      step();
    end
    chk("clear in REQ gives no abort pulse", abort_cnt, 0);
    run = 1'b0; step(); exp_seq = '0;

    // Packet A: incrementing payload, threshold boundary, grant after 3 cycles.
    t = 64'h0123_4567_89AB_CDEF;
    timestamp = t;
    preload(1'b0);
    ovr_val = 12'd1427; run = 1'b1;
    n_req = 0;
    repeat (100) begin step(); if (tx_request) n_req++; end
    chk("usedw 1427 holds off request", n_req, 0);
    ovr_val = 12'd1428;
    step();
    chk("usedw 1428 requests next cycle", tx_request, 1);
    ovr_en = 1'b0;
    run_pkt("pktA", 3, -1, -1, -1, t);

    // Two random packets: sequence 1, 2.
    for (int p = 0; p < 2; p++) begin
      t = {$urandom, $urandom}; timestamp = t;
      preload(1'b1);
      run_pkt($sformatf("pktR%0d", p), int'($urandom_range(0, 6)), -1, -1, -1, t);
    end

    // Sequence wrap.
    force dut.seq_q = 32'hFFFF_FFFF;
    step(); step();
    release dut.seq_q;
    exp_seq = 32'hFFFF_FFFF;
    for (int p = 0; p < 2; p++) begin
      t = {$urandom, $urandom}; timestamp = t;
      preload(1'b1);
      run_pkt($sformatf("wrap%0d", p), 1, -1, -1, -1, t);
    end

    // Flush at payload byte 100.
    t = {$urandom, $urandom}; timestamp = t;
    preload(1'b1);
    run_pkt("abort", 2, 16 + 100, -1, -1, t);

    // run drops at payload byte 500; packet completes, seq then clears.
    t = {$urandom, $urandom}; timestamp = t;
    preload(1'b1);
    run_pkt("rundrop", 1, -1, 16 + 500, -1, t);
    step(); step();
    exp_seq = '0;
    t = {$urandom, $urandom}; timestamp = t;
    preload(1'b1);
    run = 1'b1;
    run_pkt("afterdrop", 4, -1, -1, -1, t);

    // Reset during header byte 5.
    t = {$urandom, $urandom}; timestamp = t;
    preload(1'b1);
    run_pkt("rstpkt", 2, -1, -1, 5, t);
    chk("mid reset tx_valid", tx_valid, 0);
    chk("mid reset tx_request", tx_request, 0);
    chk("mid reset fifo_rdreq", fifo_rdreq, 0);
    chk("mid reset tx_data", tx_data, 0);
    chk("mid reset tx_last", tx_last, 0);
    chk("mid reset pkt_aborted", pkt_aborted, 0);
    chk("mid reset no reads", rd_cnt, 0);
    step();
    t = {$urandom, $urandom}; timestamp = t;
    reset = 1'b0;
    exp_seq = '0;
    run_pkt("afterrst", 2, -1, -1, -1, t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
